id_entry_buffer: RTL and testbench

ID_ENTRY_BUFFER -- requirements
Module: id_entry_buffer

---
 rtl/id_entry_buffer.sv | 128 ++++++++++++
 tb/tb_id_entry_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_entry_buffer.sv
// Keypad ID entry buffer: collects DIGITS decimal digits, supports backspace/escape,
// and offers the completed ID downstream with a valid/ready handshake.
// Optional idle timeout for partial entries is enabled by defining ID_ENTRY_TIMEOUT_EN.
module id_entry_buffer #(
  parameter int DIGITS         = 7,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key,
  input  logic                  bksp,
  input  logic                  esc,
  input  logic                  enter,
  input  logic                  id_ready,
  output logic [4*DIGITS-1:0]   ID,
  output logic                  id_valid,
  output logic                  buffer_full,
  output logic [2:0]            digit_count,
  output logic                  key_error
);

  typedef enum logic [1:0] {ENTRY, FULL, PRESENT} state_t;

  localparam logic [2:0] FULL_COUNT = 3'(DIGITS);

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] id_d;
  logic [2:0]          count_d;
  logic                valid_d;
  logic                full_d;
  logic                err_d;
  logic                timeout_hit;

`ifdef ID_ENTRY_TIMEOUT_EN
  localparam int              IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q;
  logic              strobe;

  assign strobe = key_valid | bksp | esc | enter;

  // Counter saturates on the last idle cycle; any strobe, accepted or not, restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (strobe) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end

  assign timeout_hit = !strobe && (idle_q == IDLE_MAX);
`else
  // Never true: without the timeout feature partial entries persist.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    id_d    = ID;
    count_d = digit_count;
    err_d   = 1'b0;
    case (state_q)
      PRESENT: begin
        // Entry is frozen while offered; only a key press is flagged.
        err_d = key_valid;
        if (id_valid && id_ready) begin
          state_d = ENTRY;
          id_d    = '0;
          count_d = '0;
        end
      end
      default: begin
        if (esc) begin
          state_d = ENTRY;
          id_d    = '0;
          count_d = '0;
        end else if (bksp) begin
          if (digit_count != 3'd0) begin
            state_d = ENTRY;
            id_d    = ID >> 4;
            count_d = digit_count - 3'd1;
          end
        end else if (key_valid) begin
          if ((key > 4'd9) || (state_q == FULL)) begin
            err_d = 1'b1;
          end else begin
            id_d    = {ID[4*DIGITS-5:0], key};
            count_d = digit_count + 3'd1;
            if (count_d == FULL_COUNT) state_d = FULL;
          end
        end else if (enter) begin
          if (state_q == FULL) state_d = PRESENT;
          else                 err_d   = 1'b1;
        end else if (timeout_hit && (digit_count != 3'd0)) begin
          state_d = ENTRY;
          id_d    = '0;
          count_d = '0;
        end
      end
    endcase
    valid_d = (state_d == PRESENT);
    full_d  = (count_d == FULL_COUNT);
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ENTRY;
      ID          <= '0;
      digit_count <= '0;
      id_valid    <= 1'b0;
      buffer_full <= 1'b0;
      key_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ID          <= id_d;
      digit_count <= count_d;
      id_valid    <= valid_d;
      buffer_full <= full_d;
      key_error   <= err_d;
    end
  end

endmodule

// File: tb/tb_id_entry_buffer.sv
// Self-checking bench for id_entry_buffer: directed vector table, reset/timeout
// sequences, then random stimulus against a digit-queue reference model.
module tb_id_entry_buffer;

  localparam int DIGITS = 7;
  localparam int TO     = 10;
  localparam int IW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_valid, bksp, esc, enter, id_ready;
  logic [3:0]    key;
  logic [IW-1:0] ID;
  logic          id_valid, buffer_full, key_error;
  logic [2:0]    digit_count;

  always #5 clk = ~clk;

  id_entry_buffer #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key(key), .bksp(bksp),
    .esc(esc), .enter(enter), .id_ready(id_ready), .ID(ID), .id_valid(id_valid),
    .buffer_full(buffer_full), .digit_count(digit_count), .key_error(key_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          kv;
    logic [3:0]    key;
    logic          bk, es, en, rdy;
    logic [IW-1:0] id;
    logic [2:0]    cnt;
    logic          vld, full, err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the entry is a queue of digits plus an "offered" flag.
  int unsigned m_digits[$];
  bit          m_present;
  bit          m_err;
  int          m_idle;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_outs(string tag, logic [IW-1:0] e_id, logic [2:0] e_cnt,
                            logic e_vld, logic e_full, logic e_err);
    check({tag, " ID"},          64'(ID),          64'(e_id));
    check({tag, " digit_count"}, 64'(digit_count), 64'(e_cnt));
    check({tag, " id_valid"},    64'(id_valid),    64'(e_vld));
    check({tag, " buffer_full"}, 64'(buffer_full), 64'(e_full));
    check({tag, " key_error"},   64'(key_error),   64'(e_err));
  endtask

  task automatic apply(logic kv, logic [3:0] k, logic bk, logic es, logic en, logic rdy);
    key_valid = kv; key = k; bksp = bk; esc = es; enter = en; id_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, logic rdy);
    for (int i = 0; i < n; i++) apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  function automatic void add_vec(logic kv, logic [3:0] k, logic bk, logic es, logic en,
                                  logic rdy, logic [IW-1:0] id, logic [2:0] c,
                                  logic vl, logic fl, logic er);
    vec_t v;
    v.kv = kv; v.key = k; v.bk = bk; v.es = es; v.en = en; v.rdy = rdy;
    v.id = id; v.cnt = c; v.vld = vl; v.full = fl; v.err = er;
    tbl.push_back(v);
  endfunction

  function automatic void model_reset();
    m_digits.delete();
    m_present = 1'b0;
    m_err     = 1'b0;
    m_idle    = 0;
  endfunction

  function automatic void model_step(logic kv, logic [3:0] k, logic bk, logic es,
                                     logic en, logic rdy);
    m_err = 1'b0;
    if (m_present) begin
      m_err = kv;
      if (rdy) begin
        m_digits.delete();
        m_present = 1'b0;
      end
    end else if (es) begin
      m_digits.delete();
    end else if (bk) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (kv) begin
      if (k > 4'd9 || m_digits.size() == DIGITS) m_err = 1'b1;
      else m_digits.push_back(int'(k));
    end else if (en) begin
      if (m_digits.size() == DIGITS) m_present = 1'b1;
      else m_err = 1'b1;
    end
`ifdef ID_ENTRY_TIMEOUT_EN
    if (kv || bk || es || en) m_idle = 0;
    else m_idle++;
    if (!(kv || bk || es || en) && !m_present && m_digits.size() > 0 && m_idle >= TO)
      m_digits.delete();
`endif
  endfunction

  function automatic logic [IW-1:0] model_id();
    logic [IW-1:0] v = '0;
    foreach (m_digits[i]) v = (v << 4) | IW'(m_digits[i]);
    return v;
  endfunction

  initial begin
    key_valid = 1'b0; key = 4'd0; bksp = 1'b0; esc = 1'b0; enter = 1'b0; id_ready = 1'b0;
    reset = 1'b1;

    // kv key bk es en rdy | ID cnt vld full err
    add_vec(1, 4'd1, 0,0,0,0, 28'h1,       3'd1, 0,0,0);
    add_vec(1, 4'd2, 0,0,0,0, 28'h12,      3'd2, 0,0,0);
    add_vec(1, 4'd3, 0,0,0,0, 28'h123,     3'd3, 0,0,0);
    add_vec(1, 4'd4, 0,0,0,0, 28'h1234,    3'd4, 0,0,0);
    add_vec(1, 4'd5, 0,0,0,0, 28'h12345,   3'd5, 0,0,0);
    add_vec(1, 4'd6, 0,0,0,0, 28'h123456,  3'd6, 0,0,0);
    add_vec(1, 4'd7, 0,0,0,0, 28'h1234567, 3'd7, 0,1,0);
    add_vec(0, 4'd0, 0,0,1,0, 28'h1234567, 3'd7, 1,1,0);
    add_vec(0, 4'd0, 0,0,0,0, 28'h1234567, 3'd7, 1,1,0);
    add_vec(1, 4'd5, 0,0,0,0, 28'h1234567, 3'd7, 1,1,1);
    add_vec(0, 4'd0, 0,1,0,0, 28'h1234567, 3'd7, 1,1,0);
    add_vec(0, 4'd0, 1,0,0,0, 28'h1234567, 3'd7, 1,1,0);
    add_vec(0, 4'd0, 0,0,0,1, 28'h0,       3'd0, 0,0,0);
    add_vec(1, 4'd9, 0,0,0,0, 28'h9,       3'd1, 0,0,0);
    add_vec(1, 4'd8, 0,0,0,0, 28'h98,      3'd2, 0,0,0);
    add_vec(1, 4'd7, 0,0,0,0, 28'h987,     3'd3, 0,0,0);
    add_vec(0, 4'd0, 1,0,0,0, 28'h98,      3'd2, 0,0,0);
    add_vec(0, 4'd0, 1,0,0,0, 28'h9,       3'd1, 0,0,0);
    add_vec(0, 4'd0, 1,0,0,0, 28'h0,       3'd0, 0,0,0);
    add_vec(0, 4'd0, 1,0,0,0, 28'h0,       3'd0, 0,0,0);
    add_vec(1, 4'hA, 0,0,0,0, 28'h0,       3'd0, 0,0,1);
    add_vec(1, 4'd1, 0,0,0,0, 28'h1,       3'd1, 0,0,0);
    add_vec(1, 4'd2, 0,0,0,0, 28'h12,      3'd2, 0,0,0);
    add_vec(1, 4'd3, 0,0,0,0, 28'h123,     3'd3, 0,0,0);
    add_vec(0, 4'd0, 0,0,1,0, 28'h123,     3'd3, 0,0,1);
    add_vec(1, 4'd4, 0,0,0,0, 28'h1234,    3'd4, 0,0,0);
    add_vec(1, 4'd5, 0,1,0,0, 28'h0,       3'd0, 0,0,0);
    add_vec(1, 4'hF, 1,0,0,0, 28'h0,       3'd0, 0,0,0);
    add_vec(1, 4'd0, 0,0,0,0, 28'h0,       3'd1, 0,0,0);
    add_vec(1, 4'd1, 0,0,0,0, 28'h01,      3'd2, 0,0,0);
    add_vec(1, 4'd2, 0,0,0,0, 28'h012,     3'd3, 0,0,0);
    add_vec(1, 4'd3, 0,0,0,0, 28'h0123,    3'd4, 0,0,0);
    add_vec(1, 4'd4, 0,0,0,0, 28'h01234,   3'd5, 0,0,0);
    add_vec(1, 4'd5, 0,0,0,0, 28'h012345,  3'd6, 0,0,0);
    add_vec(1, 4'd6, 0,0,0,0, 28'h0123456, 3'd7, 0,1,0);
    add_vec(1, 4'd8, 0,0,0,0, 28'h0123456, 3'd7, 0,1,1);
    add_vec(1, 4'hC, 0,0,0,0, 28'h0123456, 3'd7, 0,1,1);
    add_vec(0, 4'd0, 1,0,0,0, 28'h012345,  3'd6, 0,0,0);
    add_vec(1, 4'd7, 0,0,0,0, 28'h0123457, 3'd7, 0,1,0);
    add_vec(0, 4'd0, 0,0,1,1, 28'h0123457, 3'd7, 1,1,0);
    add_vec(0, 4'd0, 0,0,0,0, 28'h0123457, 3'd7, 1,1,0);
    add_vec(0, 4'd0, 0,0,1,1, 28'h0,       3'd0, 0,0,0);
    add_vec(0, 4'd0, 0,0,1,0, 28'h0,       3'd0, 0,0,1);

    // Reset state, then release away from an edge; row 0 lands on the first edge after.
    #12;
    check_outs("reset", '0, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].kv, tbl[i].key, tbl[i].bk, tbl[i].es, tbl[i].en, tbl[i].rdy);
      check_outs($sformatf("vec%0d", i), tbl[i].id, tbl[i].cnt, tbl[i].vld, tbl[i].full,
                 tbl[i].err);
    end

    // Asynchronous reset while the ID is being offered.
    for (int d = 1; d <= DIGITS; d++) apply(1'b1, 4'(d), 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("present before reset", 64'(id_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_outs("async reset", '0, 3'd0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    apply(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("first key after reset", 28'h5, 3'd1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    apply(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ID_ENTRY_TIMEOUT_EN
    idle(TO - 1, 1'b0);
    check_outs("before timeout", 28'h3, 3'd1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    check_outs("after timeout", '0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int d = 1; d <= DIGITS; d++) apply(1'b1, 4'(d), 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2 * TO, 1'b0);
    check_outs("present no timeout", 28'h1234567, 3'd7, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    check_outs("present drain", '0, 3'd0, 1'b0, 1'b0, 1'b0);
`else
    idle(3 * TO, 1'b0);
    check_outs("entry persists", 28'h3, 3'd1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Random phase against the reference model.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      logic       kv, bk, es, en, rdy;
      logic [3:0] k;
      kv  = ($urandom_range(0, 99) < 45);
      k   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      bk  = ($urandom_range(0, 99) < 7);
      es  = ($urandom_range(0, 99) < 3);
      en  = ($urandom_range(0, 99) < 20);
      rdy = ($urandom_range(0, 99) < 35);
      model_step(kv, k, bk, es, en, rdy);
      apply(kv, k, bk, es, en, rdy);
      check_outs($sformatf("rand%0d", c), model_id(), 3'(m_digits.size()), m_present,
                 (m_digits.size() == DIGITS), m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
